controle_multiciclo: RTL
========================

// Module: controle_multiciclo
// PURPOSE
//  Multicycle control unit for the 8-bit nano processor. Fetches 16-bit instructions, drives the
//  8x8 register bank ports (add_r1/add_r2/add_wr/wr_en), selects the ALU op and the write-back source,
//  and holds the PC. Sits between instruction memory and the register-bank/ALU datapath.
// PARAMETERS
//  PC_W  8   width of program counter / instruction address
//  IW    16  instruction width
// PORTS
//  clk         in   1     clock, all state on rising edge
//  rst         in   1     synchronous reset, active-high
//  instr_req   out  1     fetch request, held high until instr_valid
//  instr_addr  out  PC_W  fetch address (= PC)
//  instr_valid in   1     instr_data valid this cycle (ignored when instr_req=0)
//  instr_data  in   IW    fetched instruction
//  add_r1      out  3     register bank read address 1
//  add_r2      out  3     register bank read address 2
//  add_wr      out  3     register bank write address
//  wr_en       out  1     register bank write enable, single-cycle pulse
//  wr_sel      out  1     write-data mux: 0=ALU result, 1=imm
//  imm         out  8     immediate (instr[7:0]) for LDI
//  alu_op      out  3     0 ADD,1 SUB,2 AND,3 OR,4 PASS_A
//  alu_zero    in   1     ALU result==0, sampled in EXEC
//  halted      out  1     high in HALT state
//  illegal     out  1     1-cycle pulse on undefined opcode
// BEHAVIOUR
//  Encoding: op=instr[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm=[7:0], tgt={2'b0,instr[5:0]}.
//  Ops: 0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 MOV(rd<=rs1),6 LDI(rd<=imm),7 JMP(pc<=imm),
//       8 BEQ(if R[rd]==R[rs1] pc<=tgt),F HLT; 9..E illegal -> pulse illegal, execute as NOP.
//  Reset (rst=1 at edge): state=FETCH, PC=0, IR=0, all outputs 0 (instr_req goes 1 next cycle).
//  FSM: FETCH -> DECODE -> READ -> EXEC -> WB -> FETCH; HALT is terminal until rst.
//   FETCH : instr_req=1, instr_addr=PC; stay while instr_valid=0; on valid latch IR, PC<=PC+1.
//   DECODE: drive add_r1=rs1, add_r2=rs2 (BEQ: add_r1=rd, add_r2=rs1); HLT -> HALT;
//           NOP/illegal -> FETCH; JMP -> PC<=imm, -> FETCH; LDI -> WB.
//   READ  : addresses held; bank read data is registered, valid at end of this cycle.
//   EXEC  : alu_op driven (BEQ uses SUB, MOV uses PASS_A); BEQ: if alu_zero PC<=tgt, -> FETCH.
//   WB    : wr_en=1, add_wr=rd, wr_sel=1 for LDI else 0; alu_op held stable.
//  Latency with instr_valid in first FETCH cycle: ALU ops 5 cycles, LDI 3, JMP/NOP 2, BEQ 4.
//  wr_en asserted only in WB; never in any other state or during rst.
//  PC wraps 8'hFF -> 8'h00 silently; PC+1 and branch targets computed mod 2^PC_W.
//  Address outputs hold last value outside DECODE/READ/EXEC/WB (no glitching to 0).
//  rst mid-instruction: pending write is dropped (wr_en=0 that cycle), register bank not reset here.
//  rd==rs1 (e.g. ADD r2,r2,r3): legal; read happens in READ, write in WB, no hazard.
// STRUCTURE
//  controle_pkg: opcode localparams, state encoding (FETCH..HALT), ALU op codes, field slices.
//  Sub-module decodificador_instr (combinational): IR -> {is_alu, is_ldi, is_jmp, is_beq,
//  is_hlt, is_illegal, alu_op}. FSM, PC and IR stay in controle_multiciclo.
// TESTING
//  rst, program LDI r1,0x05 ; LDI r2,0x03 ; ADD r3,r1,r2 -> wr_en pulses with add_wr=1,2,3; r3=0x08.
//  instr_valid low 4 cycles in FETCH -> instr_req held, PC unchanged, no wr_en, then resumes.
//  BEQ r1,r1,0x10 with alu_zero=1 -> instr_addr=0x10 next FETCH; alu_zero=0 -> PC+1, no wr_en.
//  JMP 0xFF ; NOP at 0xFF -> next fetch address 0x00 (wrap).
//  opcode 0xA -> illegal=1 one cycle, no wr_en; HLT -> halted=1, instr_req=0 until rst.
//  rst asserted in WB of ADD -> wr_en=0 that edge, next cycle state FETCH, instr_addr=0.

Source files
------------

// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the nano processor multicycle control unit:
// opcodes, FSM states and ALU operation codes.
package controle_multiciclo_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_MOV = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_BEQ = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } estado_t;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_PASS_A = 3'd4
  } alu_op_t;

endpackage

// File: rtl/controle_multiciclo_decodificador.sv
// Combinational opcode decoder: classifies the instruction class and picks
// the ALU operation used in EXEC/WB.
module decodificador_instr
  import controle_multiciclo_pkg::*;
(
  input  logic [3:0] op,
  output logic       is_alu,
  output logic       is_ldi,
  output logic       is_jmp,
  output logic       is_beq,
  output logic       is_hlt,
  output logic       is_illegal,
  output logic [2:0] alu_op
);

  alu_op_t sel;

  always_comb begin
    is_alu     = 1'b0;
    is_ldi     = 1'b0;
    is_jmp     = 1'b0;
    is_beq     = 1'b0;
    is_hlt     = 1'b0;
    is_illegal = 1'b0;
    sel        = ALU_ADD;
    case (op)
      OP_NOP: ;
      OP_ADD: begin is_alu = 1'b1; sel = ALU_ADD;    end
      OP_SUB: begin is_alu = 1'b1; sel = ALU_SUB;    end
      OP_AND: begin is_alu = 1'b1; sel = ALU_AND;    end
      OP_OR:  begin is_alu = 1'b1; sel = ALU_OR;     end
      OP_MOV: begin is_alu = 1'b1; sel = ALU_PASS_A; end
      OP_LDI: is_ldi = 1'b1;
      OP_JMP: is_jmp = 1'b1;
      // equality test is a subtraction checked through alu_zero
      OP_BEQ: begin is_beq = 1'b1; sel = ALU_SUB; end
      OP_HLT: is_hlt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
    alu_op = sel;
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: fetches 16-bit instructions, sequences the
// register bank / ALU datapath through FETCH-DECODE-READ-EXEC-WB and holds the PC.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int unsigned PC_W = 8,
  parameter int unsigned IW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            instr_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic            instr_valid,
  input  logic [IW-1:0]   instr_data,
  output logic [2:0]      add_r1,
  output logic [2:0]      add_r2,
  output logic [2:0]      add_wr,
  output logic            wr_en,
  output logic            wr_sel,
  output logic [7:0]      imm,
  output logic [2:0]      alu_op,
  input  logic            alu_zero,
  output logic            halted,
  output logic            illegal
);

  estado_t         state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [IW-1:0]   ir, ir_n;

  logic [3:0]      f_op;
  logic [2:0]      f_rd, f_rs1, f_rs2;
  logic [PC_W-1:0] imm_pc, tgt_pc;

  logic is_alu, is_ldi, is_jmp, is_beq, is_hlt, is_illegal;

  assign f_op   = ir[15:12];
  assign f_rd   = ir[11:9];
  assign f_rs1  = ir[8:6];
  assign f_rs2  = ir[5:3];
  assign imm_pc = PC_W'(ir[7:0]);
  assign tgt_pc = PC_W'(ir[5:0]);

  decodificador_instr u_dec (
    .op         (f_op),
    .is_alu     (is_alu),
    .is_ldi     (is_ldi),
    .is_jmp     (is_jmp),
    .is_beq     (is_beq),
    .is_hlt     (is_hlt),
    .is_illegal (is_illegal),
    .alu_op     (alu_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    case (state)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_n    = instr_data;
          pc_n    = pc + PC_W'(1);
          state_n = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_hlt) begin
          state_n = ST_HALT;
        end else if (is_jmp) begin
          pc_n    = imm_pc;
          state_n = ST_FETCH;
        end else if (is_ldi) begin
          state_n = ST_WB;
        end else if (is_alu || is_beq) begin
          state_n = ST_READ;
        end else begin
          state_n = ST_FETCH;
        end
      end
      ST_READ: state_n = ST_EXEC;
      ST_EXEC: begin
        if (is_beq) begin
          if (alu_zero) pc_n = tgt_pc;
          state_n = ST_FETCH;
        end else begin
          state_n = ST_WB;
        end
      end
      ST_WB:   state_n = ST_FETCH;
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_FETCH;
    endcase
  end

  // Strobes are masked by rst so a write pending in WB is dropped on the reset edge.
  assign instr_req  = (state == ST_FETCH) && !rst;
  assign wr_en      = (state == ST_WB) && !rst;
  assign illegal    = (state == ST_DECODE) && is_illegal && !rst;
  assign halted     = (state == ST_HALT);
  assign instr_addr = pc;

  // Fields come straight from IR, which only changes at the end of FETCH,
  // so they keep their last value until the next instruction is decoded.
  assign add_r1 = is_beq ? f_rd  : f_rs1;
  assign add_r2 = is_beq ? f_rs1 : f_rs2;
  assign add_wr = f_rd;
  assign wr_sel = is_ldi;
  assign imm    = ir[7:0];

endmodule
